// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared encodings for the RV32I MEM-stage load/store unit.
//   - load/store type encodings driven by the EX/MEM seg reg
//   - load/store FSM state enum
//   - byte-lane write-enable masks
//   - misalignment helper used by the top
package rv32_mem_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } load_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_type_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } mem_state_e;

    localparam logic [3:0] LANE_B    = 4'b0001;
    localparam logic [3:0] LANE_H_LO = 4'b0011;
    localparam logic [3:0] LANE_H_HI = 4'b1100;
    localparam logic [3:0] LANE_W    = 4'b1111;

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] lt,
                                           input logic [1:0] st,
                                           input logic [1:0] a);
        logic half;
        logic word;
        half = (lt == LD_LH) || (lt == LD_LHU) || (st == ST_SH);
        word = (lt == LD_LW) || (st == ST_SW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load data aligner / extender.
// Ports:
//   rsp_data   in  32  raw word returned by data memory
//   addr_lo    in  2   byte offset of the load address
//   load_type  in  3   load encoding (rv32_mem_pkg)
//   load_data  out 32  selected byte/half/word, sign- or zero-extended
module mem_load_ext
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rsp_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rsp_data[7:0];
            2'd1:    byte_sel = rsp_data[15:8];
            2'd2:    byte_sel = rsp_data[23:16];
            default: byte_sel = rsp_data[31:24];
        endcase
        half_sel = addr_lo[1] ? rsp_data[31:16] : rsp_data[15:0];

        case (load_type)
            LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data = {24'h000000, byte_sel};
            LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  load_data = {16'h0000, half_sel};
            LD_LW:   load_data = rsp_data;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit of the RV32I core.
// Drives a valid/ready data-memory port, aligns/extends load data, stalls the
// pipeline while an access is pending and holds the MEM/WB seg reg.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   bubbleW, flushW                WB seg-reg hold / clear
//   load_type_MEM, store_type_MEM  access type (rv32_mem_pkg encodings)
//   addr_MEM, store_data_MEM       byte address, unshifted store data
//   result_MEM, reg_dest_MEM       non-load writeback value, destination reg
//   dmem_req_*                     request channel (valid/ready, addr, we, wdata)
//   dmem_rsp_valid, dmem_rsp_data  load response
//   stall_mem                      hold IF..MEM, bubble into WB
//   misalign_exc, bus_err          1-cycle exception pulses
//   reg_dest_WB, data_WB, reg_write_WB  MEM/WB seg reg outputs
module mem_access_unit
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubbleW,
    input  logic        flushW,
    input  logic [2:0]  load_type_MEM,
    input  logic [1:0]  store_type_MEM,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic [31:0] result_MEM,
    input  logic [4:0]  reg_dest_MEM,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic [3:0]  dmem_req_we,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic        stall_mem,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic [4:0]  reg_dest_WB,
    output logic [31:0] data_WB,
    output logic        reg_write_WB
);

    mem_state_e       state;
    logic [CNT_W-1:0] ctr;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        go;
    logic        store_done;
    logic        rsp_done;
    logic        timeout_fire;
    logic        stall_i;
    logic        req_valid_i;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [31:0] ext_data;

    mem_load_ext u_load_ext (
        .rsp_data  (dmem_rsp_data),
        .addr_lo   (addr_MEM[1:0]),
        .load_type (load_type_MEM),
        .load_data (ext_data)
    );

    always_comb begin
        is_load      = (load_type_MEM != LD_NONE);
        is_store     = (store_type_MEM != ST_NONE);
        misaligned   = (is_load || is_store) &&
                       is_misaligned(load_type_MEM, store_type_MEM, addr_MEM[1:0]);
        go           = (is_load || is_store) && !misaligned;
        store_done   = (state == IDLE) && go && is_store && dmem_req_ready;
        rsp_done     = (state == WAIT_RSP) && dmem_rsp_valid;
        timeout_fire = (state == WAIT_RSP) && !dmem_rsp_valid && (ctr == CNT_W'(TIMEOUT - 1));
        stall_i      = go && !store_done && !rsp_done && !timeout_fire;
        req_valid_i  = rst_n && (state == IDLE) && go;
    end

    // Store lane formatter: data is replicated across lanes, we selects the lanes.
    always_comb begin
        st_we    = '0;
        st_wdata = '0;
        case (store_type_MEM)
            ST_SB: begin
                st_we    = LANE_B << addr_MEM[1:0];
                st_wdata = {4{store_data_MEM[7:0]}};
            end
            ST_SH: begin
                st_we    = addr_MEM[1] ? LANE_H_HI : LANE_H_LO;
                st_wdata = {2{store_data_MEM[15:0]}};
            end
            ST_SW: begin
                st_we    = LANE_W;
                st_wdata = store_data_MEM;
            end
            default: ;
        endcase
    end

    // Outputs are forced low while rst_n is asserted.
    always_comb begin
        dmem_req_valid = req_valid_i;
        dmem_req_addr  = req_valid_i ? {addr_MEM[31:2], 2'b00} : '0;
        dmem_req_we    = req_valid_i ? st_we : '0;
        dmem_req_wdata = (req_valid_i && is_store) ? st_wdata : '0;
        stall_mem      = rst_n && stall_i;
        misalign_exc   = rst_n && misaligned;
        bus_err        = rst_n && timeout_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ctr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && is_load && dmem_req_ready) begin
                        state <= WAIT_RSP;
                        ctr   <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid || timeout_fire) begin
                        state <= IDLE;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_dest_WB  <= '0;
            data_WB      <= '0;
            reg_write_WB <= 1'b0;
        end else if (!bubbleW) begin
            if (flushW || stall_i) begin
                reg_dest_WB  <= '0;
                data_WB      <= '0;
                reg_write_WB <= 1'b0;
            end else begin
                reg_dest_WB  <= reg_dest_MEM;
                data_WB      <= is_load ? ext_data : result_MEM;
                reg_write_WB <= (reg_dest_MEM != 5'd0) && !misaligned && !timeout_fire;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, random transactions
// checked against a behavioural model, and hand-written reset/bubble/flush sequences.
module tb_mem_access_unit;
    import rv32_mem_pkg::*;

    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bubbleW, flushW;
    logic [2:0]  load_type_MEM;
    logic [1:0]  store_type_MEM;
    logic [31:0] addr_MEM, store_data_MEM, result_MEM;
    logic [4:0]  reg_dest_MEM;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic [3:0]  dmem_req_we;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        stall_mem, misalign_exc, bus_err;
    logic [4:0]  reg_dest_WB;
    logic [31:0] data_WB;
    logic        reg_write_WB;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bubbleW(bubbleW), .flushW(flushW),
        .load_type_MEM(load_type_MEM), .store_type_MEM(store_type_MEM),
        .addr_MEM(addr_MEM), .store_data_MEM(store_data_MEM),
        .result_MEM(result_MEM), .reg_dest_MEM(reg_dest_MEM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
        .dmem_req_wdata(dmem_req_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_data(dmem_rsp_data), .stall_mem(stall_mem),
        .misalign_exc(misalign_exc), .bus_err(bus_err),
        .reg_dest_WB(reg_dest_WB), .data_WB(data_WB), .reg_write_WB(reg_write_WB)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] res;
        logic [4:0]  rd;
        int          rw;       // cycles ready is held low before acceptance
        int          rspw;     // WAIT_RSP cycles before the response arrives
        bit          no_rsp;
        logic [31:0] rdata;
        int          e_valid;  // cycles with dmem_req_valid high
        int          e_stall;  // cycles with stall_mem high
        int          e_mis;
        int          e_berr;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        bit          chk_data;
        logic        e_wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] lt, input logic [1:0] st,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] res, input logic [4:0] rd,
                                 input int rw, input int rspw, input bit no_rsp,
                                 input logic [31:0] rdata,
                                 input int e_valid, input int e_stall, input int e_mis,
                                 input int e_berr, input logic [3:0] e_we,
                                 input logic [31:0] e_wdata, input logic [31:0] e_data,
                                 input bit chk_data, input logic e_wr);
        vec_t v;
        v.lt = lt; v.st = st; v.a = a; v.d = d; v.res = res; v.rd = rd;
        v.rw = rw; v.rspw = rspw; v.no_rsp = no_rsp; v.rdata = rdata;
        v.e_valid = e_valid; v.e_stall = e_stall; v.e_mis = e_mis; v.e_berr = e_berr;
        v.e_we = e_we; v.e_wdata = e_wdata; v.e_data = e_data;
        v.chk_data = chk_data; v.e_wr = e_wr;
        return v;
    endfunction

    // Reference model: derives all expectations from access size, offset and handshake timing.
    function automatic vec_t model(input vec_t vi);
        vec_t v;
        int size, off;
        bit ld, acc, mis, sgn;
        logic [31:0] raw, mask;
        v = vi;
        ld  = (v.lt != 3'd0);
        acc = ld || (v.st != 2'd0);
        if (v.st != 2'd0) size = (v.st == ST_SB) ? 1 : (v.st == ST_SH) ? 2 : 4;
        else size = (v.lt == LD_LB || v.lt == LD_LBU) ? 1 :
                    (v.lt == LD_LH || v.lt == LD_LHU) ? 2 : 4;
        sgn = (v.lt == LD_LB) || (v.lt == LD_LH);
        off = int'(v.a[1:0]);
        mis = acc && ((off % size) != 0);
        v.e_mis  = mis ? 1 : 0;
        v.e_berr = (acc && !mis && ld && v.no_rsp) ? 1 : 0;
        if (!acc || mis) begin
            v.e_valid = 0; v.e_stall = 0;
        end else if (!ld) begin
            v.e_valid = v.rw + 1; v.e_stall = v.rw;
        end else if (v.no_rsp) begin
            v.e_valid = v.rw + 1; v.e_stall = v.rw + int'(TIMEOUT);
        end else begin
            v.e_valid = v.rw + 1; v.e_stall = v.rw + 1 + v.rspw;
        end
        for (int i = 0; i < 4; i++) begin
            v.e_we[i] = (v.st != 2'd0) && !mis && (i >= off) && (i < off + size);
            v.e_wdata[8*i +: 8] = v.d[8*(i % size) +: 8];
        end
        raw  = v.rdata >> (8 * off);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        raw  = raw & mask;
        if (sgn && raw[8*size-1]) raw = raw | ~mask;
        v.e_data   = ld ? raw : v.res;
        v.chk_data = !(ld && (mis || v.no_rsp));
        v.e_wr     = (v.rd != 5'd0) && !mis && (v.e_berr == 0);
        return v;
    endfunction

    task automatic idle_inputs();
        load_type_MEM = LD_NONE; store_type_MEM = ST_NONE;
        addr_MEM = '0; store_data_MEM = '0; result_MEM = '0; reg_dest_MEM = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    endtask

    // Called at posedge+1; holds the MEM inputs until stall_mem drops, acting as memory.
    task automatic txn(input vec_t v, input string tag);
        int cyc, wcnt, stalls, vcnt, misp, berr;
        bit accepted, done;
        cyc = 0; wcnt = 0; stalls = 0; vcnt = 0; misp = 0; berr = 0;
        accepted = 0; done = 0;
        load_type_MEM = v.lt; store_type_MEM = v.st; addr_MEM = v.a;
        store_data_MEM = v.d; result_MEM = v.res; reg_dest_MEM = v.rd;
        while (!done && cyc < 600) begin
            @(negedge clk);
            dmem_req_ready = !accepted && (cyc >= v.rw);
            dmem_rsp_valid = accepted && !v.no_rsp && (wcnt == v.rspw);
            dmem_rsp_data  = dmem_rsp_valid ? v.rdata : $urandom;
            #1;
            if (dmem_req_valid) begin
                vcnt++;
                chk({tag, " req_addr"}, dmem_req_addr, {v.a[31:2], 2'b00});
                chk({tag, " req_we"}, {28'h0, dmem_req_we}, {28'h0, v.e_we});
                if (v.st != 2'd0) chk({tag, " req_wdata"}, dmem_req_wdata, v.e_wdata);
            end
            if (stall_mem) stalls++;
            if (misalign_exc) misp++;
            if (bus_err) berr++;
            if (!stall_mem) done = 1;
            if (accepted) wcnt++;
            if (dmem_req_valid && dmem_req_ready) accepted = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s completion: stall_mem still high after %0d cycles, required low", tag, cyc);
        end
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(v.e_stall));
        chk({tag, " valid_cycles"}, 32'(vcnt), 32'(v.e_valid));
        chk({tag, " misalign_pulses"}, 32'(misp), 32'(v.e_mis));
        chk({tag, " bus_err_pulses"}, 32'(berr), 32'(v.e_berr));
        chk({tag, " reg_write_WB"}, {31'h0, reg_write_WB}, {31'h0, v.e_wr});
        chk({tag, " reg_dest_WB"}, {27'h0, reg_dest_WB}, {27'h0, v.rd});
        if (v.chk_data) chk({tag, " data_WB"}, data_WB, v.e_data);
        idle_inputs();
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1);
    end

    initial begin
        //                lt      st     addr         sdata         res           rd  rw spw nr rdata         val stl mis ber we    wdata         data          chk wr
        tbl[0]  = mkv(LD_NONE, ST_SW, 32'h100, 32'hDEADBEEF, 32'h0,        5'd0,  0, 0, 0, 32'h0,        1, 0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0,        1, 1'b0);
        tbl[1]  = mkv(LD_NONE, ST_SH, 32'h102, 32'h00001234, 32'h0,        5'd0,  2, 0, 0, 32'h0,        3, 2, 0, 0, 4'hC, 32'h12341234, 32'h0,        1, 1'b0);
        tbl[2]  = mkv(LD_LB,   ST_NONE, 32'h103, 32'h0,      32'h0,        5'd5,  0, 2, 0, 32'h80000000, 1, 3, 0, 0, 4'h0, 32'h0,        32'hFFFFFF80, 1, 1'b1);
        tbl[3]  = mkv(LD_LBU,  ST_NONE, 32'h103, 32'h0,      32'h0,        5'd5,  0, 2, 0, 32'h80000000, 1, 3, 0, 0, 4'h0, 32'h0,        32'h00000080, 1, 1'b1);
        tbl[4]  = mkv(LD_LW,   ST_NONE, 32'h101, 32'h0,      32'h0,        5'd7,  0, 0, 0, 32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h0,        0, 1'b0);
        tbl[5]  = mkv(LD_LH,   ST_NONE, 32'h102, 32'h0,      32'h0,        5'd3,  1, 0, 0, 32'h80017FFF, 2, 2, 0, 0, 4'h0, 32'h0,        32'hFFFF8001, 1, 1'b1);
        tbl[6]  = mkv(LD_LHU,  ST_NONE, 32'h100, 32'h0,      32'h0,        5'd3,  0, 0, 0, 32'h80017FFF, 1, 1, 0, 0, 4'h0, 32'h0,        32'h00007FFF, 1, 1'b1);
        tbl[7]  = mkv(LD_LW,   ST_NONE, 32'h204, 32'h0,      32'h0,        5'd31, 0, 1, 0, 32'hCAFEF00D, 1, 2, 0, 0, 4'h0, 32'h0,        32'hCAFEF00D, 1, 1'b1);
        tbl[8]  = mkv(LD_NONE, ST_SB, 32'h013, 32'h000000A5, 32'h0,        5'd0,  0, 0, 0, 32'h0,        1, 0, 0, 0, 4'h8, 32'hA5A5A5A5, 32'h0,        1, 1'b0);
        tbl[9]  = mkv(LD_NONE, ST_NONE, 32'h0,   32'h0,      32'h12345678, 5'd9,  0, 0, 0, 32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        32'h12345678, 1, 1'b1);
        tbl[10] = mkv(LD_NONE, ST_SH, 32'h101, 32'h0000BEEF, 32'h00000077, 5'd0,  0, 0, 0, 32'h0,        0, 0, 1, 0, 4'h0, 32'h0,        32'h00000077, 1, 1'b0);
        tbl[11] = mkv(LD_LB,   ST_NONE, 32'h101, 32'h0,      32'h0,        5'd0,  0, 0, 0, 32'h00007F00, 1, 1, 0, 0, 4'h0, 32'h0,        32'h0000007F, 1, 1'b0);
        tbl[12] = mkv(LD_LB,   ST_NONE, 32'h102, 32'h0,      32'h0,        5'd12, 0, 0, 0, 32'h00FF0000, 1, 1, 0, 0, 4'h0, 32'h0,        32'hFFFFFFFF, 1, 1'b1);
        tbl[13] = mkv(LD_LW,   ST_NONE, 32'h040, 32'h0,      32'h0,        5'd6,  1, 0, 1, 32'h0,        2, 1 + TIMEOUT, 0, 1, 4'h0, 32'h0,  32'h0,        0, 1'b0);

        // Reset state, with an aligned load presented on the inputs.
        rst_n = 1'b0; bubbleW = 1'b0; flushW = 1'b0;
        idle_inputs();
        load_type_MEM = LD_LW; addr_MEM = 32'h100; reg_dest_MEM = 5'd2; dmem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_valid", {31'h0, dmem_req_valid}, 32'h0);
        chk("reset stall_mem", {31'h0, stall_mem}, 32'h0);
        chk("reset reg_write_WB", {31'h0, reg_write_WB}, 32'h0);
        chk("reset data_WB", data_WB, 32'h0);
        chk("reset reg_dest_WB", {27'h0, reg_dest_WB}, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) txn(tbl[i], $sformatf("vec%0d", i));

        // Random transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            int k;
            k = int'($urandom_range(0, 8));
            rv = mkv(LD_NONE, ST_NONE, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0, $urandom,
                     0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1'b0);
            if (k >= 1 && k <= 5) rv.lt = 3'(k);
            else if (k >= 6) rv.st = 2'(k - 5);
            if (($urandom & 1) == 1) rv.a[1:0] = 2'b00;
            txn(model(rv), $sformatf("rnd%0d", i));
        end

        // Async reset while a load is waiting for its response.
        load_type_MEM = LD_LW; addr_MEM = 32'h300; reg_dest_MEM = 5'd4; dmem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rstwait req_valid", {31'h0, dmem_req_valid}, 32'h1);
        @(posedge clk);
        #1;
        dmem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwait stall before reset", {31'h0, stall_mem}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstwait stall_mem", {31'h0, stall_mem}, 32'h0);
        chk("rstwait req_valid low", {31'h0, dmem_req_valid}, 32'h0);
        chk("rstwait reg_write_WB", {31'h0, reg_write_WB}, 32'h0);
        chk("rstwait data_WB", data_WB, 32'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h5A5A5A5A;
        @(negedge clk);
        #1;
        chk("late rsp stall_mem", {31'h0, stall_mem}, 32'h0);
        chk("late rsp bus_err", {31'h0, bus_err}, 32'h0);
        @(posedge clk);
        #1;
        dmem_rsp_valid = 1'b0;
        chk("late rsp reg_write_WB", {31'h0, reg_write_WB}, 32'h0);
        txn(mkv(LD_LW, ST_NONE, 32'h200, 32'h0, 32'h0, 5'd8, 0, 1, 0, 32'h13579BDF,
                1, 2, 0, 0, 4'h0, 32'h0, 32'h13579BDF, 1, 1'b1), "post_reset LW");

        // WB seg reg: bubble holds, flush clears.
        result_MEM = 32'hAAAA5555; reg_dest_MEM = 5'd10;
        @(posedge clk);
        #1;
        chk("wb load reg_dest", {27'h0, reg_dest_WB}, 32'd10);
        chk("wb load data", data_WB, 32'hAAAA5555);
        chk("wb load reg_write", {31'h0, reg_write_WB}, 32'h1);
        result_MEM = 32'hBBBB0000; reg_dest_MEM = 5'd11; bubbleW = 1'b1;
        @(posedge clk);
        #1;
        chk("bubble reg_dest", {27'h0, reg_dest_WB}, 32'd10);
        chk("bubble data", data_WB, 32'hAAAA5555);
        bubbleW = 1'b0; flushW = 1'b1;
        @(posedge clk);
        #1;
        chk("flush reg_dest", {27'h0, reg_dest_WB}, 32'h0);
        chk("flush data", data_WB, 32'h0);
        chk("flush reg_write", {31'h0, reg_write_WB}, 32'h0);
        flushW = 1'b0;
        idle_inputs();
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
